// File: rtl/uart_tx_serializer_if.sv
// Byte/strobe handshake between the AXI4 UART bridge and the 8N1 serializer,
// plus the serializer's idle level and the serial line it drives.
interface uart_tx_serializer_if;
    logic [7:0] txbyte;
    logic       senddata;
    logic       txdone;
    logic       tx;

    modport master (
        output txbyte,
        output senddata,
        input  txdone,
        input  tx
    );

    modport slave (
        input  txbyte,
        input  senddata,
        output txdone,
        output tx
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter: latches one byte per request taken while idle and shifts
// out start, 8 data bits LSB-first and stop, each CLKS_PER_BIT clocks long.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_serializer_if.slave  bus
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          txdone_q, txdone_d;
    logic          baud_end;

    assign baud_end = (baud_q == BAUD_LAST);

    // tx/txdone are computed from the next state so they appear in the same
    // cycle the state register changes, while staying purely registered.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        txdone_d = txdone_q;

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = 3'd0;
                if (bus.senddata) begin
                    shift_d  = bus.txbyte;
                    state_d  = S_START;
                    tx_d     = 1'b0;
                    txdone_d = 1'b0;
                end else begin
                    tx_d     = 1'b1;
                    txdone_d = 1'b1;
                end
            end
            S_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    baud_d   = '0;
                    state_d  = S_IDLE;
                    tx_d     = 1'b1;
                    txdone_d = 1'b1;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: begin
                state_d  = S_IDLE;
                baud_d   = '0;
                bit_d    = 3'd0;
                tx_d     = 1'b1;
                txdone_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            shift_q  <= 8'h00;
            tx_q     <= 1'b1;
            txdone_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            txdone_q <= txdone_d;
        end
    end

    assign bus.tx     = tx_q;
    assign bus.txdone = txdone_q;

endmodule
